serdesphy_rx_fifo: RTL and testbench

//  Receive-path buffer: 8-bit words from the RX decoder/deserializer are queued and

---
 rtl/serdesphy_pkg.sv | 16 +
 rtl/serdesphy_nibble_sel.sv | 12 +
 rtl/serdesphy_rx_fifo.sv | 110 +++++++++++
 tb/tb_serdesphy_rx_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
// Constants shared by the SerDes PHY RX and TX FIFOs: default geometry and word/nibble widths.
package serdesphy_pkg;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;
  localparam int NIBBLE_W       = 4;
  localparam int WORD_W         = 8;

  // Phase 0 sends the "first" nibble, phase 1 the other half of the word.
  function automatic logic [NIBBLE_W-1:0] pick_nibble(input logic [WORD_W-1:0] word,
                                                      input logic              phase,
                                                      input logic              lsn_first);
    logic hi_sel;
    hi_sel = phase ^ ~lsn_first;
    return hi_sel ? word[WORD_W-1:NIBBLE_W] : word[NIBBLE_W-1:0];
  endfunction
endpackage

// File: rtl/serdesphy_nibble_sel.sv
// Word-to-nibble mux for the RX FIFO head word; ordering set by LSN_FIRST.
module serdesphy_nibble_sel
  import serdesphy_pkg::*;
#(
  parameter bit LSN_FIRST = 1'b1
) (
  input  logic [WORD_W-1:0]   word_i,
  input  logic                phase_i,
  output logic [NIBBLE_W-1:0] nibble_o
);
  assign nibble_o = pick_nibble(word_i, phase_i, LSN_FIRST);
endmodule

// File: rtl/serdesphy_rx_fifo.sv
// RX FIFO: queues decoded 8-bit words and drains them as 4-bit nibbles to the pin mux.
// Optional word-count output enabled by defining SERDESPHY_RX_FIFO_LEVEL_EN.
module serdesphy_rx_fifo
  import serdesphy_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit LSN_FIRST  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                flush,
  input  logic                clear_errors,
  input  logic                write_enable,
  input  logic                write_valid,
  input  logic [WORD_W-1:0]   data_in,
  input  logic                read_enable,
  output logic [NIBBLE_W-1:0] nibble_out,
  output logic                nibble_valid,
  output logic                nibble_last,
  output logic                full,
  output logic                empty,
  output logic                overflow,
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
  output logic [ADDR_WIDTH:0] level,
`endif
  output logic                underflow
);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                phase_q, phase_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic [WORD_W-1:0]   mem_q [FIFO_DEPTH];
  logic [NIBBLE_W-1:0] head_nibble;
  logic                wr_req, wr_acc, pop;

  // Flags come straight from the pre-edge pointers, so a same-cycle pop never rescues a write.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign wr_req       = enable & write_enable & write_valid;
  assign wr_acc       = wr_req & ~full & ~flush;
  assign nibble_valid = enable & ~empty;
  assign nibble_last  = phase_q;
  assign pop          = read_enable & nibble_valid;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
  assign level = wr_ptr_q - rd_ptr_q;
`endif

  serdesphy_nibble_sel #(.LSN_FIRST(LSN_FIRST)) u_nibble_sel (
    .word_i   (mem_q[rd_ptr_q[ADDR_WIDTH-1:0]]),
    .phase_i  (phase_q),
    .nibble_o (head_nibble)
  );

  assign nibble_out = empty ? '0 : head_nibble;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    phase_d     = phase_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (enable) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        phase_d  = 1'b0;
      end else begin
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop) begin
          phase_d = ~phase_q;
          if (phase_q) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
      end
      // Setting takes priority over a same-cycle clear.
      if (clear_errors)          overflow_d  = 1'b0;
      if (wr_req & full)         overflow_d  = 1'b1;
      if (clear_errors)          underflow_d = 1'b0;
      if (read_enable & empty)   underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      phase_q     <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      phase_q     <= phase_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; empty masks stale contents on the output.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= data_in;
  end
endmodule

// File: tb/tb_serdesphy_rx_fifo.sv
// Directed bench for serdesphy_rx_fifo: vector table plus multi-cycle corner-case sequences.
module tb_serdesphy_rx_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0, flush = 1'b0, clear_errors = 1'b0;
  logic       write_enable = 1'b0, write_valid = 1'b0, read_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [3:0] nibble_out;
  logic       nibble_valid, nibble_last, full, empty, overflow, underflow;
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
  logic [3:0] level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serdesphy_rx_fifo #(.FIFO_DEPTH(8), .ADDR_WIDTH(3), .LSN_FIRST(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .clear_errors (clear_errors),
    .write_enable (write_enable),
    .write_valid  (write_valid),
    .data_in      (data_in),
    .read_enable  (read_enable),
    .nibble_out   (nibble_out),
    .nibble_valid (nibble_valid),
    .nibble_last  (nibble_last),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
    .level        (level),
`endif
    .underflow    (underflow)
  );

  always #21 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b1; flush = 1'b0; clear_errors = 1'b0;
    write_enable = 1'b0; write_valid = 1'b0; read_enable = 1'b0; data_in = 8'h00;
  endtask

  task automatic wr_word(input logic [7:0] w);
    write_enable = 1'b1; write_valid = 1'b1; data_in = w;
    tick();
    write_enable = 1'b0; write_valid = 1'b0;
  endtask

  // Pops both nibbles of the head word and checks them against w (low nibble first).
  task automatic pop_word(input string name, input logic [7:0] w);
    read_enable = 1'b1;
    #1;
    chk({name, "_lo"}, 32'(nibble_out), 32'(w[3:0]));
    chk({name, "_lo_last"}, 32'(nibble_last), 32'd0);
    tick();
    chk({name, "_hi"}, 32'(nibble_out), 32'(w[7:4]));
    chk({name, "_hi_last"}, 32'(nibble_last), 32'd1);
    tick();
    read_enable = 1'b0;
  endtask

  typedef struct {
    logic       en, fl, clr, we, wv;
    logic [7:0] din;
    logic       re;
    logic [3:0] nib;
    logic       vld, last, fu, em, ovf, unf;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [3:0] exp_q[$];
    int written, lowcnt, cyc;
    bit did_low, done;
    logic [7:0] w;
    logic wr, rd, en;

    // en fl clr we wv din re | nib vld last full empty ovf unf
    tbl[0]  = '{1,0,0,1,1,8'hA5,0, 4'h5,1,0,0,0,0,0};
    tbl[1]  = '{1,0,0,0,0,8'h00,1, 4'hA,1,1,0,0,0,0};
    tbl[2]  = '{1,0,0,0,0,8'h00,1, 4'h0,0,0,0,1,0,0};
    tbl[3]  = '{1,0,0,0,0,8'h00,1, 4'h0,0,0,0,1,0,1};
    tbl[4]  = '{1,0,0,0,0,8'h00,0, 4'h0,0,0,0,1,0,1};
    tbl[5]  = '{0,0,0,1,1,8'h3C,0, 4'h0,0,0,0,1,0,1};
    tbl[6]  = '{1,0,1,0,0,8'h00,0, 4'h0,0,0,0,1,0,0};
    tbl[7]  = '{1,0,0,1,1,8'h3C,0, 4'hC,1,0,0,0,0,0};
    tbl[8]  = '{0,0,0,0,0,8'h00,0, 4'hC,0,0,0,0,0,0};
    tbl[9]  = '{0,0,0,0,0,8'h00,1, 4'hC,0,0,0,0,0,0};
    tbl[10] = '{1,0,0,0,0,8'h00,1, 4'h3,1,1,0,0,0,0};
    tbl[11] = '{1,1,0,1,1,8'h77,0, 4'h0,0,0,0,1,0,0};
    tbl[12] = '{1,0,1,0,0,8'h00,1, 4'h0,0,0,0,1,0,1};
    tbl[13] = '{1,0,1,0,0,8'h00,0, 4'h0,0,0,0,1,0,0};

    // Reset state
    idle_inputs();
    enable = 1'b0;
    #5;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(nibble_valid), 32'd0);
    chk("rst_last", 32'(nibble_last), 32'd0);
    chk("rst_nibble", 32'(nibble_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
    chk("rst_level", 32'(level), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Table: single word, underflow, enable-low freeze, flush, set-over-clear
    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en; flush = tbl[i].fl; clear_errors = tbl[i].clr;
      write_enable = tbl[i].we; write_valid = tbl[i].wv; data_in = tbl[i].din;
      read_enable = tbl[i].re;
      tick();
      chk($sformatf("v%0d_nibble", i), 32'(nibble_out), 32'(tbl[i].nib));
      chk($sformatf("v%0d_valid", i), 32'(nibble_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d_last", i), 32'(nibble_last), 32'(tbl[i].last));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(tbl[i].fu));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(tbl[i].em));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
    end
    idle_inputs();

    // Fill, overflow on 9th write, ordered drain, clear
    for (int i = 0; i < 8; i++) wr_word(8'(i));
    chk("fill_full", 32'(full), 32'd1);
    wr_word(8'hFF);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_still_full", 32'(full), 32'd1);
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
    chk("fill_level", 32'(level), 32'd8);
`endif
    for (int i = 0; i < 8; i++) pop_word($sformatf("drain%0d", i), 8'(i));
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // Full + write + pop on phase 1: write rejected, one word freed
    for (int i = 0; i < 8; i++) wr_word(8'h10 + 8'(i));
    read_enable = 1'b1;
    tick();
    chk("fp_phase1_nib", 32'(nibble_out), 32'h1);
    write_enable = 1'b1; write_valid = 1'b1; data_in = 8'hEE;
    tick();
    write_enable = 1'b0; write_valid = 1'b0; read_enable = 1'b0;
    chk("fp_ovf", 32'(overflow), 32'd1);
    chk("fp_full", 32'(full), 32'd0);
    chk("fp_nib", 32'(nibble_out), 32'h1);
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
    chk("fp_level", 32'(level), 32'd7);
`endif
    for (int i = 1; i < 8; i++) pop_word($sformatf("fp%0d", i), 8'h10 + 8'(i));
    chk("fp_empty", 32'(empty), 32'd1);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;

    // Streaming 24 words through the wrap with an enable-low window mid-word
    written = 0; lowcnt = 0; did_low = 0; done = 0;
    for (cyc = 0; cyc < 400 && !done; cyc++) begin
      if (!did_low && cyc > 30 && (exp_q.size() % 2) == 1) begin
        did_low = 1; lowcnt = 3;
      end
      en = (lowcnt == 0);
      if (lowcnt > 0) lowcnt--;
      wr = (written < 24) && (((exp_q.size() + 1) / 2) < 8) && (cyc % 3 != 2);
      rd = (exp_q.size() > 0) && ((cyc % 2 == 0) || written == 24 || !en);
      w  = 8'(written * 37 + 5);
      enable = en; write_enable = wr; write_valid = wr; data_in = w; read_enable = rd;
      #1;
      chk("st_valid", 32'(nibble_valid), 32'(en && exp_q.size() > 0));
      if (en && rd) chk("st_nibble", 32'(nibble_out), 32'(exp_q[0]));
      tick();
      if (en && rd) void'(exp_q.pop_front());
      if (en && wr) begin
        exp_q.push_back(w[3:0]);
        exp_q.push_back(w[7:4]);
        written++;
      end
      if (written == 24 && (exp_q.size() % 2) == 1) done = 1;
    end
    idle_inputs();
    chk("st_finished", 32'(done), 32'd1);
    chk("st_low_window", 32'(did_low), 32'd1);
    chk("st_midword_last", 32'(nibble_last), 32'd1);
    enable = 1'b0;
    tick();
    chk("st_freeze_valid", 32'(nibble_valid), 32'd0);
    enable = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_last", 32'(nibble_last), 32'd0);
    chk("fl_valid", 32'(nibble_valid), 32'd0);
    chk("fl_unf", 32'(underflow), 32'd0);
    wr_word(8'h9B);
    pop_word("post_flush", 8'h9B);
    chk("post_flush_empty", 32'(empty), 32'd1);

    // Async reset mid-word with a sticky flag set
    wr_word(8'h42);
    wr_word(8'h43);
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    for (int i = 0; i < 9; i++) wr_word(8'hCC);
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    #5;
    rst_n = 1'b0;
    #2;
    chk("ar_empty", 32'(empty), 32'd1);
    chk("ar_full", 32'(full), 32'd0);
    chk("ar_valid", 32'(nibble_valid), 32'd0);
    chk("ar_last", 32'(nibble_last), 32'd0);
    chk("ar_ovf", 32'(overflow), 32'd0);
    chk("ar_unf", 32'(underflow), 32'd0);
`ifdef SERDESPHY_RX_FIFO_LEVEL_EN
    chk("ar_level", 32'(level), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
